// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one byte-level I2C master between N_REQ requesters.
// Optional watchdog with m_abort port when I2C_ARB_TIMEOUT_EN is defined.
module i2c_bus_arbiter #(
   parameter int N_REQ       = 2,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [N_REQ-1:0]     req_rw,
   input  logic [7*N_REQ-1:0]   req_dev_addr,
   input  logic [8*N_REQ-1:0]   req_reg_addr,
   input  logic [8*N_REQ-1:0]   req_wdata,
   output logic [N_REQ-1:0]     gnt,
   output logic [N_REQ-1:0]     done,
   output logic [N_REQ-1:0]     err,
   output logic [7:0]           rdata,
   output logic                 m_start,
   output logic                 m_rw,
   output logic [6:0]           m_dev_addr,
   output logic [7:0]           m_reg_addr,
   output logic [7:0]           m_wdata,
   input  logic                 m_done,
   input  logic                 m_nack,
   input  logic [7:0]           m_rdata
`ifdef I2C_ARB_TIMEOUT_EN
   ,
   output logic                 m_abort
`endif
);

   localparam int          PW = $clog2(N_REQ);
   localparam int unsigned NU = N_REQ;

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("i2c_bus_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC >= 1");
   end

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, RESP} state_t;

   state_t         state;
   logic [PW-1:0]  ptr;
   logic [PW-1:0]  winner;
   logic [PW-1:0]  sel_idx;
   logic           sel_found;
   int unsigned    k;

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] cnt;
`endif

   // First active request at or above ptr, wrapping modulo N_REQ.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      k         = 0;
      for (int unsigned i = 0; i < NU; i++) begin
         k = (32'(ptr) + i) % NU;
         if (!sel_found && req[PW'(k)]) begin
            sel_found = 1'b1;
            sel_idx   = PW'(k);
         end
      end
   end

   // m_start is registered out of LAUNCH, so it appears one cycle after gnt.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= '0;
         winner     <= '0;
         gnt        <= '0;
         done       <= '0;
         err        <= '0;
         rdata      <= '0;
         m_start    <= 1'b0;
         m_rw       <= 1'b0;
         m_dev_addr <= '0;
         m_reg_addr <= '0;
         m_wdata    <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
         cnt        <= '0;
         m_abort    <= 1'b0;
`endif
      end else begin
         m_start <= 1'b0;
         done    <= '0;
         err     <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
         m_abort <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (sel_found) begin
                  winner     <= sel_idx;
                  gnt        <= N_REQ'(1) << sel_idx;
                  m_rw       <= req_rw[sel_idx];
                  m_dev_addr <= req_dev_addr[7*sel_idx +: 7];
                  m_reg_addr <= req_reg_addr[8*sel_idx +: 8];
                  m_wdata    <= req_wdata[8*sel_idx +: 8];
                  state      <= LAUNCH;
               end
            end
            LAUNCH: begin
               m_start <= 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
               cnt     <= '0;
`endif
               state   <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (m_done) begin
                  rdata <= m_rdata;
                  done  <= N_REQ'(1) << winner;
                  err   <= m_nack ? (N_REQ'(1) << winner) : '0;
                  state <= RESP;
               end
`ifdef I2C_ARB_TIMEOUT_EN
               else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                  m_abort <= 1'b1;
                  done    <= N_REQ'(1) << winner;
                  err     <= N_REQ'(1) << winner;
                  state   <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end
            RESP: begin
               gnt   <= '0;
               ptr   <= (winner == PW'(N_REQ - 1)) ? '0 : winner + 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter: stimulus pushes expected grants, commands
// and responses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_i2c_bus_arbiter;
   localparam int N = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req = '0;
   logic [N-1:0]   req_rw = '0;
   logic [7*N-1:0] req_dev_addr = '0;
   logic [8*N-1:0] req_reg_addr = '0;
   logic [8*N-1:0] req_wdata = '0;
   logic [N-1:0]   gnt, done, err;
   logic [7:0]     rdata;
   logic           m_start, m_rw;
   logic [6:0]     m_dev_addr;
   logic [7:0]     m_reg_addr, m_wdata;
   logic           m_done = 1'b0;
   logic           m_nack = 1'b0;
   logic [7:0]     m_rdata = '0;
`ifdef I2C_ARB_TIMEOUT_EN
   logic           m_abort;
`endif

`ifdef I2C_ARB_TIMEOUT_EN
   i2c_bus_arbiter #(.N_REQ(N), .TIMEOUT_CYC(15)) dut (
`else
   i2c_bus_arbiter #(.N_REQ(N)) dut (
`endif
      .clk(clk), .rst(rst), .req(req), .req_rw(req_rw),
      .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
      .gnt(gnt), .done(done), .err(err), .rdata(rdata),
      .m_start(m_start), .m_rw(m_rw), .m_dev_addr(m_dev_addr),
      .m_reg_addr(m_reg_addr), .m_wdata(m_wdata),
      .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
`ifdef I2C_ARB_TIMEOUT_EN
      , .m_abort(m_abort)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {logic rw; logic [6:0] dev; logic [7:0] rg; logic [7:0] wd;} cmd_t;
   typedef struct {logic nack; logic [7:0] rd;} mresp_t;
   typedef struct {int idx; logic e; logic [7:0] rd;} resp_t;

   int     gq[$];
   cmd_t   cq[$];
   mresp_t mq[$];
   resp_t  rq[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor
   logic [N-1:0] prev_gnt = '0;
   int           mg;
   cmd_t         mc;
   resp_t        mr;
   always @(negedge clk) begin
      if (!rst) begin
         if (gnt != '0) begin
            chk("gnt_onehot", $countones(gnt), 1);
            if (prev_gnt == '0) begin
               if (gq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_grant actual=%b required=none", gnt);
               end else begin
                  mg = gq.pop_front();
                  chk("grant", 32'(gnt), 32'(1) << mg);
               end
            end
         end
         if (m_start) begin
            if (cq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_m_start actual=1 required=0");
            end else begin
               mc = cq.pop_front();
               chk("m_rw", 32'(m_rw), 32'(mc.rw));
               chk("m_dev_addr", 32'(m_dev_addr), 32'(mc.dev));
               chk("m_reg_addr", 32'(m_reg_addr), 32'(mc.rg));
               chk("m_wdata", 32'(m_wdata), 32'(mc.wd));
            end
         end
         if (done != '0) begin
            if (rq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done actual=%b required=0", done);
            end else begin
               mr = rq.pop_front();
               chk("done", 32'(done), 32'(1) << mr.idx);
               chk("err", 32'(err), mr.e ? (32'(1) << mr.idx) : 32'(0));
               chk("rdata", 32'(rdata), 32'(mr.rd));
            end
         end else if (err != '0) begin
            checks++; errors++;
            $display("FAIL err_without_done actual=%b required=0", err);
         end
      end
      prev_gnt = gnt;
   end

   // Master model: answers each m_start from mq two cycles later
   initial begin
      mresp_t r;
      forever begin
         @(negedge clk);
         if (m_start && mq.size() > 0) begin
            r = mq.pop_front();
            repeat (2) @(negedge clk);
            m_done  = 1'b1;
            m_nack  = r.nack;
            m_rdata = r.rd;
            @(negedge clk);
            m_done  = 1'b0;
            m_nack  = 1'b0;
         end
      end
   end

   task automatic set_fields(input int i, input logic rw, input logic [6:0] dev,
                             input logic [7:0] rg, input logic [7:0] wd);
      req_rw[i]             = rw;
      req_dev_addr[7*i +: 7] = dev;
      req_reg_addr[8*i +: 8] = rg;
      req_wdata[8*i +: 8]    = wd;
   endtask

   task automatic expect_txn(input int i, input logic rw, input logic [6:0] dev,
                             input logic [7:0] rg, input logic [7:0] wd,
                             input logic nack, input logic [7:0] mrd);
      cmd_t c; mresp_t m; resp_t r;
      c.rw = rw; c.dev = dev; c.rg = rg; c.wd = wd;
      m.nack = nack; m.rd = mrd;
      r.idx = i; r.e = nack; r.rd = mrd;
      gq.push_back(i); cq.push_back(c); mq.push_back(m); rq.push_back(r);
   endtask

   task automatic wait_done(input string name);
      bit seen = 0;
      for (int n = 0; n < 200 && !seen; n++) begin
         @(negedge clk);
         if (done != '0) seen = 1;
      end
      if (!seen) chk({name, "_done_timeout"}, 32'(0), 32'(1));
   endtask

   task automatic run1(input int i, input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                       input logic [7:0] wd, input logic nack, input logic [7:0] mrd);
      set_fields(i, rw, dev, rg, wd);
      expect_txn(i, rw, dev, rg, wd, nack, mrd);
      req[i] = 1'b1;
      wait_done("run1");
      req[i] = 1'b0;
   endtask

   task automatic run_multi(input logic [N-1:0] mask, input int cnt);
      int got = 0;
      req = mask;
      for (int n = 0; n < 400 && got < cnt; n++) begin
         @(negedge clk);
         if (done != '0) got++;
      end
      chk("multi_done_count", 32'(got), 32'(cnt));
      req = '0;
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_m_start", 32'(m_start), 0);
      chk("rst_m_dev_addr", 32'(m_dev_addr), 0);
      rst = 1'b0;
      @(negedge clk);

      // Single write with latency checks
      set_fields(0, 1'b0, 7'h50, 8'h10, 8'hA5);
      expect_txn(0, 1'b0, 7'h50, 8'h10, 8'hA5, 1'b0, 8'h00);
      req[0] = 1'b1;
      @(negedge clk);
      chk("lat_gnt", 32'(gnt), 32'h1);
      chk("lat_no_start", 32'(m_start), 0);
      @(negedge clk);
      chk("lat_start", 32'(m_start), 1);
      wait_done("write");
      req[0] = 1'b0;

      // Read from requester 1
      run1(1, 1'b1, 7'h21, 8'h05, 8'h00, 1'b0, 8'h3C);

      // Write afterwards: rdata holds 0x3C until the next completion
      set_fields(0, 1'b0, 7'h50, 8'h11, 8'h5A);
      expect_txn(0, 1'b0, 7'h50, 8'h11, 8'h5A, 1'b0, 8'h3C);
      req[0] = 1'b1;
      repeat (3) @(negedge clk);
      chk("rdata_held", 32'(rdata), 32'h3C);
      wait_done("write2");
      req[0] = 1'b0;

      // NACK on requester 0, ptr moves to 1
      run1(0, 1'b0, 7'h44, 8'h20, 8'h01, 1'b1, 8'h3C);
      set_fields(1, 1'b0, 7'h12, 8'h34, 8'h56);
      expect_txn(1, 1'b0, 7'h12, 8'h34, 8'h56, 1'b0, 8'h99);
      run_multi(2'b11, 1);

      // Contention: ptr=0, both held for 4 transactions
      set_fields(0, 1'b0, 7'h0A, 8'hA0, 8'hAA);
      set_fields(1, 1'b1, 7'h0B, 8'hB0, 8'hBB);
      expect_txn(0, 1'b0, 7'h0A, 8'hA0, 8'hAA, 1'b0, 8'h11);
      expect_txn(1, 1'b1, 7'h0B, 8'hB0, 8'hBB, 1'b0, 8'h22);
      expect_txn(0, 1'b0, 7'h0A, 8'hA0, 8'hAA, 1'b0, 8'h33);
      expect_txn(1, 1'b1, 7'h0B, 8'hB0, 8'hBB, 1'b0, 8'h44);
      run_multi(2'b11, 4);

      // ptr -> 1, then reset during WAIT_DONE of a requester-1 transaction
      run1(0, 1'b0, 7'h60, 8'h01, 8'h02, 1'b0, 8'h55);
      begin
         cmd_t c;
         bit   seen = 0;
         set_fields(1, 1'b0, 7'h61, 8'h03, 8'h04);
         c.rw = 1'b0; c.dev = 7'h61; c.rg = 8'h03; c.wd = 8'h04;
         gq.push_back(1); cq.push_back(c);
         req[1] = 1'b1;
         for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (m_start) seen = 1;
         end
         chk("rst_test_start_seen", 32'(seen), 1);
         repeat (2) @(negedge clk);
         #2 rst = 1'b1;
         #1;
         chk("arst_gnt", 32'(gnt), 0);
         chk("arst_m_start", 32'(m_start), 0);
         chk("arst_m_dev_addr", 32'(m_dev_addr), 0);
         chk("arst_rdata", 32'(rdata), 0);
         req = '0;
         @(negedge clk);
         rst = 1'b0;
      end
      set_fields(0, 1'b1, 7'h30, 8'h31, 8'h00);
      set_fields(1, 1'b1, 7'h40, 8'h41, 8'h00);
      expect_txn(0, 1'b1, 7'h30, 8'h31, 8'h00, 1'b0, 8'h81);
      expect_txn(1, 1'b1, 7'h40, 8'h41, 8'h00, 1'b0, 8'h82);
      run_multi(2'b11, 2);

      // Master never completes
      begin
         cmd_t c;
         set_fields(1, 1'b0, 7'h70, 8'h71, 8'h72);
         c.rw = 1'b0; c.dev = 7'h70; c.rg = 8'h71; c.wd = 8'h72;
         gq.push_back(1); cq.push_back(c);
`ifdef I2C_ARB_TIMEOUT_EN
         begin
            resp_t r;
            bit    seen = 0;
            int    n_ab = -1;
            r.idx = 1; r.e = 1'b1; r.rd = 8'h82;
            rq.push_back(r);
            req[1] = 1'b1;
            for (int n = 0; n < 50 && !seen; n++) begin
               @(negedge clk);
               if (m_start) seen = 1;
            end
            for (int n = 1; n <= 50 && n_ab < 0; n++) begin
               @(negedge clk);
               if (m_abort) n_ab = n;
            end
            chk("abort_latency", 32'(n_ab), 15);
            chk("abort_done", 32'(done), 32'h2);
            chk("abort_err", 32'(err), 32'h2);
            req[1] = 1'b0;
         end
`else
         begin
            resp_t r;
            int    nd = 0;
            req[1] = 1'b1;
            repeat (100) begin
               @(negedge clk);
               if (done != '0) nd++;
            end
            chk("no_completion", 32'(nd), 0);
            chk("gnt_held", 32'(gnt), 32'h2);
            r.idx = 1; r.e = 1'b0; r.rd = 8'h77;
            rq.push_back(r);
            m_rdata = 8'h77;
            m_done  = 1'b1;
            wait_done("late");
            m_done  = 1'b0;
            req[1]  = 1'b0;
         end
`endif
      end

      repeat (5) @(negedge clk);
      chk("gq_empty", 32'(gq.size()), 0);
      chk("cq_empty", 32'(cq.size()), 0);
      chk("rq_empty", 32'(rq.size()), 0);
      chk("mq_empty", 32'(mq.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
